// File: rtl/gf_mul_seq.sv
// gf_mul_seq: sequential GF(2^M) multiplier with optional multiply-accumulate.
//
// Consumes D bits of multiplier b per cycle (MSB first, Horner form), so a
// product takes M/D cycles in CALC. Operands and results are in polynomial
// basis. With acc_en set, the result is a*b XOR the previously delivered
// result, which suits syndrome and Chien-sum loops.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand pair valid          in_ready   block can accept operands
//   a, b       multiplicand / multiplier   acc_en     XOR product into acc_q
//   out_valid  result valid                out_ready  downstream accepts result
//   dout       result                      busy       multiplication in progress
module gf_mul_seq #(
  parameter int         M    = 8,
  parameter logic [M:0] POLY = 9'h11D,
  parameter int         D    = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [M-1:0] a,
  input  logic [M-1:0] b,
  input  logic         acc_en,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [M-1:0] dout,
  output logic         busy
);

  localparam int STEPS = M / D;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST = CW'(STEPS - 1);
  // Reduction term: x^M is congruent to the low M bits of the polynomial.
  localparam logic [M-1:0] RED = POLY[M-1:0];

  generate
    if (M < 2 || M > 16 || D < 1 || (M % D) != 0 || POLY[M] != 1'b1) begin : g_bad_params
      $error("gf_mul_seq: illegal parameters (M in 2..16, D divides M, POLY[M]=1)");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [M-1:0]    a_q, a_d;
  logic [M-1:0]    b_q, b_d;
  logic [M-1:0]    p_q, p_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            acc_sel_q, acc_sel_d;
  logic [M-1:0]    acc_q, acc_d;
  logic [M-1:0]    dout_q, dout_d;

  // Digit step results for this cycle.
  logic [M-1:0]    p_step;
  logic [M-1:0]    b_step;

  // Multiply by x modulo POLY.
  function automatic logic [M-1:0] xtime(input logic [M-1:0] p);
    return {p[M-2:0], 1'b0} ^ (p[M-1] ? RED : '0);
  endfunction

  // D Horner steps unrolled: p = p*x + b_msb*a, consuming b from the top.
  always_comb begin
    // NOTE: blocking assignments here chain the D unrolled steps within one
    // cycle; the flops below use non-blocking so all state updates together.
    p_step = p_q;
    b_step = b_q;
    for (int i = 0; i < D; i++) begin
      p_step = xtime(p_step) ^ (b_step[M-1] ? a_q : '0);
      b_step = b_step << 1;
    end
  end

  always_comb begin
    // NOTE: every *_d holds its flop value by default so no path infers a latch.
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    acc_sel_d = acc_sel_q;
    acc_d     = acc_q;
    dout_d    = dout_q;

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d       = a;
          b_d       = b;
          acc_sel_d = acc_en;
          p_d       = '0;
          cnt_d     = '0;
          state_d   = CALC;
        end
      end
      CALC: begin
        p_d   = p_step;
        b_d   = b_step;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          dout_d  = p_step ^ (acc_sel_q ? acc_q : '0);
          state_d = DONE;
        end
      end
      DONE: begin
        // Every delivered result seeds the next accumulation, so a
        // non-accumulating operation starts a fresh chain.
        if (out_ready) begin
          acc_d   = dout_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: all state, including datapath registers, is reset so a reset
  // mid-operation leaves no stale result or accumulator behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      a_q       <= '0;
      b_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      acc_sel_q <= 1'b0;
      acc_q     <= '0;
      dout_q    <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      b_q       <= b_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      acc_sel_q <= acc_sel_d;
      acc_q     <= acc_d;
      dout_q    <= dout_d;
    end
  end

  // Outputs decode only the state register: no out_ready -> in_ready path.
  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q == CALC);
  assign dout      = dout_q;

endmodule

// File: doc/gf_mul_seq.md
Name: gf_mul_seq

Overview:
- Parametrised sequential GF(2^M) multiplier. Both operands are variable (no compile-time constant).
- Processes D bits of multiplier operand b per cycle, MSB first, with a valid/ready handshake on input and output.
- Optional multiply-accumulate: XORs the new product into the last delivered result, for syndrome and Chien-sum style loops in the RS/BCH decoder datapath.
- All operands and results are in polynomial (standard) basis.

Parameters:
- M, 8, field degree (2..16).
- POLY, 9'h11D, primitive polynomial of width M+1; bit M must be 1. Default is x^8+x^4+x^3+x^2+1.
- D, 1, bits of b consumed per cycle. Must divide M. Latency is M/D cycles.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  operand pair valid
- in_ready  out  1  block can accept operands
- a  in  M  multiplicand
- b  in  M  multiplier
- acc_en  in  1  1 = result is a*b XOR acc_q; 0 = result is a*b
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- dout  out  M  result
- busy  out  1  state is CALC

Behaviour:
- Reset (async, immediate):
  - state=IDLE; in_ready=1; out_valid=0; busy=0.
  - dout=0; acc_q=0; internal p=0 and cnt=0.
- Elaboration checks: M%D!=0, POLY[M]!=1, or M outside 2..16 is a fatal error ($error / generate guard).
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: latch a_q=a, b_q=b, acc_q_sel=acc_en; clear p=0 and cnt=0; go to CALC.
- CALC, once per cycle:
  - Repeat D times, unrolled combinationally: p = xtime(p) ^ (b_q[M-1] ? a_q : 0); then b_q = b_q<<1.
  - xtime(p) = (p<<1) ^ (p[M-1] ? POLY[M-1:0] : 0).
  - cnt increments by 1 each cycle.
  - When cnt reaches M/D-1, the cycle's update completes the product. On that edge, load dout = p_next ^ (acc_q_sel ? acc_q : 0), set out_valid=1, go to DONE.
- Latency: with acceptance at edge k, out_valid rises at edge k+M/D. Examples: M=8, D=1 gives 8 cycles; D=8 gives 1 cycle.
- DONE:
  - out_valid=1; dout is held stable while out_ready=0 (unbounded back-pressure); in_ready=0.
  - On out_ready: acc_q=dout; out_valid=0; go to IDLE.
  - No combinational path from out_ready to in_ready. Throughput is 1 result per M/D+2 cycles.
- acc_q update rules:
  - Updates only at output handshake, for every result, whether or not acc_en was set.
  - A non-accumulate operation therefore starts a new accumulation chain.
- Input handling outside IDLE: in_valid is ignored; a/b/acc_en changes have no effect.
- Reset asserted mid-CALC or in DONE: operation abandoned, no out_valid. acc_q is cleared.
- Zero operands: a=0 or b=0 gives product 0. Result is 0, or acc_q if accumulating.
- All arithmetic is carry-free XOR. Widths are exactly M; there is no overflow condition.

Test Plan:
- Reset defaults: assert rst mid-CALC (M=8, D=1, a=0x80, b=0x80, cycle 4) -> out_valid, dout, busy all 0 immediately; in_ready=1; next op a=0x03, b=0x03, acc_en=1 -> dout=0x05, proving acc_q was cleared.
- Field products, M=8, POLY=0x11D, D=1:
  - 0x02*0x80 -> 0x1D
  - 0x80*0x80 -> 0x13
  - 0x03*0x03 -> 0x05
  - 0xA7*0x01 -> 0xA7
  - 0x00*0xFF -> 0x00
  - each with out_valid exactly 8 cycles after acceptance.
- Accumulate chain: 0x02*0x80 (acc_en=0) -> 0x1D; then 0x03*0x03 (acc_en=1) -> 0x18; then 0x80*0x80 (acc_en=1) -> 0x0B; then 0x01*0x01 (acc_en=0) -> 0x01.
- Back-pressure: hold out_ready=0 for 20 cycles after out_valid -> dout stable at 0x13, in_ready=0, in_valid pulses ignored; release -> one handshake, then IDLE.
- Digit variants: rerun the product vectors with D=2, 4, 8 -> identical results; latency 4, 2, 1 cycles respectively.
- Generic field: M=4, POLY=5'h13, D=1 -> 0x8*0x2=0x3, 0xF*0xF=0xA; exhaustive 256-pair sweep against a reference model with zero mismatches.
